sync_fifo_pro: RTL and testbench

SYNC_FIFO_PRO -- requirements
Module: sync_fifo_pro

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/sync_fifo_pro_if.sv | 41 ++++
 rtl/fifo_mem.sv | 28 ++
 rtl/sync_fifo_pro.sv | 150 +++++++++++++++
 tb/tb_sync_fifo_pro.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types and elaboration helpers.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package fifo_pkg;

    // STD registers the popped word one cycle after the read; FWFT shows the
    // head word combinationally and treats read_en as a pop.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_t;

    // Address bits needed to index DEPTH entries.
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Pointer width: address bits plus one wrap bit so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_pro_if.sv
// Handshake/data bundle between a FIFO user (master) and sync_fifo_pro (slave).
// Latency: n/a (wires only).
// Backpressure: the master must honour full/empty; the FIFO drops and flags any violation.
// Ports: clear, data_in, write_en, read_en from the master; data_out, read_valid,
// status flags, count and sticky error flags from the FIFO.
interface sync_fifo_pro_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) ();

    localparam int CW = ptr_width(DEPTH);

    logic             clear;
    logic [WIDTH-1:0] data_in;
    logic             write_en;
    logic             read_en;
    logic [WIDTH-1:0] data_out;
    logic             read_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, data_in, write_en, read_en,
        input  data_out, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, data_in, write_en, read_en,
        output data_out, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the owner decides when a write is legal. Contents are never reset.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr in, rd_data out.
module fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with status flags, sticky error flags, and STD or FWFT read mode.
// Latency: STD data_out one cycle after an accepted read; FWFT head word visible the cycle after its write.
// Backpressure: writes refused while full, reads refused while empty; refused requests set overflow/underflow.
// Ports: clk, async_rst (asynchronous, active-high) plus the sync_fifo_pro_if slave bundle.
module sync_fifo_pro
    import fifo_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter int         DEPTH    = 16,
    parameter int         AF_LEVEL = DEPTH - 2,
    parameter int         AE_LEVEL = 2,
    parameter fifo_mode_t MODE     = FIFO_STD
) (
    input  logic           clk,
    input  logic           async_rst,
    sync_fifo_pro_if.slave bus
);

    localparam int AW = addr_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    // Pointers that differ in the wrap bit alone mean the FIFO is full; since
    // DEPTH is a power of two that difference is exactly DEPTH.
    localparam logic [PW-1:0] PTR_WRAP = PW'(DEPTH);
    localparam logic [PW-1:0] AF_L     = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L     = PW'(AE_LEVEL);

    // Elaboration-time parameter sanity.
    if (WIDTH < 1) begin : g_chk_width
        $error("sync_fifo_pro: WIDTH must be >= 1");
    end
    if (!is_pow2(DEPTH)) begin : g_chk_depth
        $error("sync_fifo_pro: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_chk_af
        $error("sync_fifo_pro: AF_LEVEL must lie in 0..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_chk_ae
        $error("sync_fifo_pro: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             read_valid_q, read_valid_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    logic [PW-1:0]    count_w;
    logic             full_w;
    logic             empty_w;
    logic             wr_acc;
    logic             rd_acc;
    logic             mem_wr_en;
    logic [WIDTH-1:0] mem_rd_data;

    // Status is a pure function of the registered pointers.
    always_comb begin
        count_w = wr_ptr_q - rd_ptr_q;
        full_w  = (wr_ptr_q ^ rd_ptr_q) == PTR_WRAP;
        empty_w = (wr_ptr_q == rd_ptr_q);
    end

    // Acceptance uses pre-edge flags, so a read in the same cycle never makes
    // room for a write into a full FIFO.
    assign wr_acc    = bus.write_en & ~full_w;
    assign rd_acc    = bus.read_en  & ~empty_w;
    // A write coinciding with clear is discarded, never stored.
    assign mem_wr_en = wr_acc & ~bus.clear;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        read_valid_d = 1'b0;
        data_out_d   = data_out_q;

        if (bus.clear) begin
            // Flush wins over any request this cycle; the STD output word is kept.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                read_valid_d = 1'b1;
                data_out_d   = mem_rd_data;
            end
            overflow_d  = overflow_q  | (bus.write_en & full_w);
            underflow_d = underflow_q | (bus.read_en  & empty_w);
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            read_valid_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            read_valid_q <= read_valid_d;
            data_out_q   <= data_out_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (bus.data_in),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (mem_rd_data)
    );

    // FWFT shows the head word directly and forces zero when nothing is stored,
    // so stale memory never leaks out.
    always_comb begin
        if (MODE == FIFO_FWFT) begin
            bus.data_out   = empty_w ? '0 : mem_rd_data;
            bus.read_valid = ~empty_w;
        end else begin
            bus.data_out   = data_out_q;
            bus.read_valid = read_valid_q;
        end
    end

    assign bus.count        = count_w;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_w >= AF_L);
    assign bus.almost_empty = (count_w <= AE_L);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Bench: STD and FWFT instances driven with identical stimulus, checked every cycle
// against a queue-based model, plus hand-computed literal expectations.
module tb_sync_fifo_pro;
    import fifo_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic clk = 1'b0;
    logic async_rst;
    always #5 clk = ~clk;

    sync_fifo_pro_if #(.WIDTH(W), .DEPTH(D)) if_std ();
    sync_fifo_pro_if #(.WIDTH(W), .DEPTH(D)) if_fwft ();

    sync_fifo_pro #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .MODE(FIFO_STD))
        dut_std (.clk(clk), .async_rst(async_rst), .bus(if_std));
    sync_fifo_pro #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .MODE(FIFO_FWFT))
        dut_fwft (.clk(clk), .async_rst(async_rst), .bus(if_fwft));

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model: contents as a queue, STD output register as a plain variable.
    logic [W-1:0] q[$];
    bit           m_ovf, m_udf, m_rv;
    logic [W-1:0] m_dout;

    bit           s_we, s_re, s_clr;
    logic [W-1:0] s_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_rv   = 1'b0;
        m_dout = '0;
    endtask

    // Apply one clock edge to the model using the inputs held across that edge.
    task automatic model_edge();
        int sz;
        bit racc, wacc;
        sz = q.size();
        if (async_rst) begin
            model_reset();
        end else if (s_clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rv  = 1'b0;
        end else begin
            racc = s_re && (sz != 0);
            wacc = s_we && (sz != D);
            if (s_we && sz == D) m_ovf = 1'b1;
            if (s_re && sz == 0) m_udf = 1'b1;
            m_rv = racc;
            if (racc) m_dout = q.pop_front();
            if (wacc) q.push_back(s_d);
        end
    endtask

    task automatic drive(input bit we, input bit re, input bit clr, input logic [W-1:0] d);
        s_we = we; s_re = re; s_clr = clr; s_d = d;
        if_std.write_en  = we; if_std.read_en  = re; if_std.clear  = clr; if_std.data_in  = d;
        if_fwft.write_en = we; if_fwft.read_en = re; if_fwft.clear = clr; if_fwft.data_in = d;
    endtask

    task automatic cycle(input bit we, input bit re, input bit clr, input logic [W-1:0] d);
        drive(we, re, clr, d);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Compare process: every negedge, both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int sz;
            sz = q.size();
            chk("std.count",  32'(if_std.count),        32'(sz));
            chk("std.full",   32'(if_std.full),         32'(sz == D));
            chk("std.empty",  32'(if_std.empty),        32'(sz == 0));
            chk("std.af",     32'(if_std.almost_full),  32'(sz >= AF));
            chk("std.ae",     32'(if_std.almost_empty), 32'(sz <= AE));
            chk("std.ovf",    32'(if_std.overflow),     32'(m_ovf));
            chk("std.udf",    32'(if_std.underflow),    32'(m_udf));
            chk("std.rv",     32'(if_std.read_valid),   32'(m_rv));
            chk("std.dout",   32'(if_std.data_out),     32'(m_dout));
            chk("fwft.count", 32'(if_fwft.count),       32'(sz));
            chk("fwft.full",  32'(if_fwft.full),        32'(sz == D));
            chk("fwft.empty", 32'(if_fwft.empty),       32'(sz == 0));
            chk("fwft.ovf",   32'(if_fwft.overflow),    32'(m_ovf));
            chk("fwft.udf",   32'(if_fwft.underflow),   32'(m_udf));
            chk("fwft.rv",    32'(if_fwft.read_valid),  32'(sz != 0));
            chk("fwft.dout",  32'(if_fwft.data_out),    (sz != 0) ? 32'(q[0]) : 32'd0);
        end
    end

    initial begin
        logic [W-1:0] exp_words [4];
        logic [W-1:0] wrap_in   [10];
        logic [W-1:0] wrap_out  [$];

        async_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        model_reset();
        #1;
        chk("rst.count", 32'(if_std.count),        32'd0);
        chk("rst.empty", 32'(if_std.empty),        32'd1);
        chk("rst.full",  32'(if_std.full),         32'd0);
        chk("rst.ae",    32'(if_std.almost_empty), 32'd1);
        chk("rst.af",    32'(if_std.almost_full),  32'd0);
        chk("rst.dout",  32'(if_std.data_out),     32'd0);
        chk("rst.rv",    32'(if_std.read_valid),   32'd0);
        chk("rst.fdout", 32'(if_fwft.data_out),    32'd0);
        @(negedge clk);
        @(negedge clk);
        async_rst = 1'b0;
        chk_en    = 1'b1;

        // Read on empty right after reset.
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("udf.flag",  32'(if_std.underflow),  32'd1);
        chk("udf.rv",    32'(if_std.read_valid), 32'd0);
        chk("udf.dout",  32'(if_std.data_out),   32'd0);
        chk("udf.count", 32'(if_std.count),      32'd0);
        cycle(1'b0, 1'b0, 1'b1, '0);

        // Fill, overflow, then drain in STD.
        exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33; exp_words[3] = 8'h44;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, exp_words[i]);
        chk("fill.full",  32'(if_std.full),        32'd1);
        chk("fill.af",    32'(if_std.almost_full), 32'd1);
        chk("fill.count", 32'(if_std.count),       32'd4);
        chk("fill.fhead", 32'(if_fwft.data_out),   32'h11);
        cycle(1'b1, 1'b0, 1'b0, 8'h55);
        chk("ovf.flag",  32'(if_std.overflow), 32'd1);
        chk("ovf.count", 32'(if_std.count),    32'd4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            chk("drain.dout", 32'(if_std.data_out),   32'(exp_words[i]));
            chk("drain.rv",   32'(if_std.read_valid), 32'd1);
        end
        cycle(1'b0, 1'b0, 1'b0, '0);
        chk("drain.rv_low", 32'(if_std.read_valid), 32'd0);
        chk("drain.hold",   32'(if_std.data_out),   32'h44);

        // Simultaneous read and write at count 2.
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, 8'h01);
        cycle(1'b1, 1'b0, 1'b0, 8'h02);
        cycle(1'b1, 1'b1, 1'b0, 8'hA5);
        chk("rw.count", 32'(if_std.count),    32'd2);
        chk("rw.dout",  32'(if_std.data_out), 32'h01);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("rw.second", 32'(if_std.data_out), 32'h02);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("rw.a5", 32'(if_std.data_out), 32'hA5);

        // FWFT fall-through and pop.
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, 8'h7E);
        chk("fwft.word",  32'(if_fwft.data_out),   32'h7E);
        chk("fwft.valid", 32'(if_fwft.read_valid), 32'd1);
        chk("fwft.nempt", 32'(if_fwft.empty),      32'd0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("fwft.popempty", 32'(if_fwft.empty),    32'd1);
        chk("fwft.popzero",  32'(if_fwft.data_out), 32'd0);

        // Ten write/read pairs across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            wrap_in[i] = W'($urandom);
            cycle(1'b1, 1'b0, 1'b0, wrap_in[i]);
            cycle(1'b0, 1'b1, 1'b0, '0);
            wrap_out.push_back(if_std.data_out);
        end
        for (int i = 0; i < 10; i++) chk("wrap.order", 32'(wrap_out[i]), 32'(wrap_in[i]));

        // Clear with write_en high after an overflow.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, W'(8'hC0 + i));
        cycle(1'b1, 1'b0, 1'b1, 8'hEE);
        chk("clr.count", 32'(if_std.count),    32'd0);
        chk("clr.empty", 32'(if_std.empty),    32'd1);
        chk("clr.ovf",   32'(if_std.overflow), 32'd0);

        // Full with read and write together: write refused.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, W'(8'h60 + i));
        cycle(1'b1, 1'b1, 1'b0, 8'h99);
        chk("fullrw.count", 32'(if_std.count),    32'd3);
        chk("fullrw.dout",  32'(if_std.data_out), 32'h60);

        // Asynchronous reset between edges in the middle of a burst.
        drive(1'b1, 1'b1, 1'b0, 8'h3C);
        @(posedge clk);
        model_edge();
        #2 async_rst = 1'b1;
        #1;
        chk("arst.count", 32'(if_std.count),      32'd0);
        chk("arst.empty", 32'(if_std.empty),      32'd1);
        chk("arst.rv",    32'(if_std.read_valid), 32'd0);
        chk("arst.dout",  32'(if_std.data_out),   32'd0);
        chk("arst.ovf",   32'(if_std.overflow),   32'd0);
        chk("arst.fdout", 32'(if_fwft.data_out),  32'd0);
        model_reset();
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, 8'h12);
        async_rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 8'h34);
        chk("postrst.count", 32'(if_std.count),    32'd1);
        chk("postrst.head",  32'(if_fwft.data_out), 32'h34);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 2, W'($urandom));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
